// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage between execute (L2) and write-back (L3).
//
// Accepts an ALU result and store data from L2. Loads and stores run against
// the data RAM through a req/gnt/rvalid handshake. While an access is in
// flight the upstream pipeline is stalled. Load data is aligned and extended
// before it is registered into L3. The register file has no write enable, so
// every cycle that must not write drives rd_l3 = 0.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   valid_l2, load_l2,         L2 instruction: valid, memory op type,
//   store_l2, funct3_l2,       access size, destination register,
//   rd_l2, alu_q_l2, wdata_l2  ALU result / byte address, store data
//   stall_l2                   hold L2 and upstream (combinational)
//   valid_l3, load_l3, err_l3  L3 valid, L3 is a load, L3 is a faulting access
//   rd_l3, alu_q_l3,           write-back destination (0 = no write),
//   ram_rdata_l3               registered ALU result, aligned load data
//   ram_req, ram_we, ram_addr, RAM request side: request, write, word address,
//   ram_wdata, ram_wstrb       lane-replicated store data, byte strobes
//   ram_gnt, ram_rvalid,       RAM response side: request accepted,
//   ram_rdata                  read data valid, read word
module lsu_stage #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_l2,
  input  logic          load_l2,
  input  logic          store_l2,
  input  logic [2:0]    funct3_l2,
  input  logic [4:0]    rd_l2,
  input  logic [31:0]   alu_q_l2,
  input  logic [31:0]   wdata_l2,
  output logic          stall_l2,
  output logic          valid_l3,
  output logic          load_l3,
  output logic          err_l3,
  output logic [4:0]    rd_l3,
  output logic [31:0]   alu_q_l3,
  output logic [31:0]   ram_rdata_l3,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wstrb,
  input  logic          ram_gnt,
  input  logic          ram_rvalid,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Size/alignment legality: H needs addr[0]=0, W needs addr[1:0]=0,
  // funct3 011/110/111 are never legal.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~off[0];
      3'b010:         ok = (off == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte strobes for a store of the given size at byte offset off.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      2'b10:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Store data replicated to every lane so the strobes alone pick the target.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  d = {{24{b[7]}}, b};
      3'b001:  d = {{16{h[15]}}, h};
      3'b100:  d = {24'h00_0000, b};
      3'b101:  d = {16'h0000, h};
      default: d = word;
    endcase
    return d;
  endfunction

  state_e        state_r, state_s;
  logic          mem_op_s, ok_s, capture_s;
  logic          l3_valid_s, l3_load_s, l3_err_s;
  logic [4:0]    l3_rd_s;
  logic [31:0]   l3_alu_s, l3_rdata_s;

  // Captured request and the load context needed when the data returns.
  logic [AW-1:0] req_addr_r;
  logic          req_we_r;
  logic [31:0]   req_wdata_r;
  logic [3:0]    req_wstrb_r;
  logic [2:0]    req_f3_r;
  logic [1:0]    req_off_r;
  logic [4:0]    req_rd_r;
  logic [31:0]   req_alu_r;

  assign mem_op_s  = valid_l2 & (load_l2 | store_l2);
  assign ok_s      = access_ok(funct3_l2, alu_q_l2[1:0]);

  assign ram_req   = (state_r == S_REQ);
  assign ram_we    = req_we_r;
  assign ram_addr  = req_addr_r;
  assign ram_wdata = req_wdata_r;
  assign ram_wstrb = req_wstrb_r;

  // Next-state, stall and next L3 contents; bubble is the default.
  always_comb begin
    state_s    = state_r;
    stall_l2   = 1'b0;
    capture_s  = 1'b0;
    l3_valid_s = 1'b0;
    l3_load_s  = 1'b0;
    l3_err_s   = 1'b0;
    l3_rd_s    = 5'd0;
    l3_alu_s   = alu_q_l3;
    l3_rdata_s = ram_rdata_l3;
    case (state_r)
      S_IDLE: begin
        l3_alu_s = alu_q_l2;
        if (mem_op_s && ok_s) begin
          capture_s = 1'b1;
          stall_l2  = 1'b1;
          state_s   = S_REQ;
        end else if (mem_op_s) begin
          // Faulting access retires in one cycle without touching the RAM.
          l3_valid_s = 1'b1;
          l3_err_s   = 1'b1;
        end else begin
          l3_valid_s = valid_l2;
          l3_rd_s    = valid_l2 ? rd_l2 : 5'd0;
        end
      end
      S_REQ: begin
        if (ram_gnt && req_we_r) begin
          // Store retires on grant; release L2 in the same cycle.
          l3_valid_s = 1'b1;
          l3_alu_s   = req_alu_r;
          state_s    = S_IDLE;
        end else if (ram_gnt) begin
          stall_l2 = 1'b1;
          state_s  = S_RESP;
        end else begin
          stall_l2 = 1'b1;
        end
      end
      S_RESP: begin
        if (ram_rvalid) begin
          l3_valid_s = 1'b1;
          l3_load_s  = 1'b1;
          l3_rd_s    = req_rd_r;
          l3_alu_s   = req_alu_r;
          l3_rdata_s = align_load(req_f3_r, req_off_r, ram_rdata);
          state_s    = S_IDLE;
        end else begin
          stall_l2 = 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // L3 pipeline registers and the held RAM request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_l3     <= 1'b0;
      load_l3      <= 1'b0;
      err_l3       <= 1'b0;
      rd_l3        <= 5'd0;
      alu_q_l3     <= 32'd0;
      ram_rdata_l3 <= 32'd0;
      req_addr_r   <= {AW{1'b0}};
      req_we_r     <= 1'b0;
      req_wdata_r  <= 32'd0;
      req_wstrb_r  <= 4'b0000;
      req_f3_r     <= 3'b000;
      req_off_r    <= 2'b00;
      req_rd_r     <= 5'd0;
      req_alu_r    <= 32'd0;
    end else begin
      valid_l3     <= l3_valid_s;
      load_l3      <= l3_load_s;
      err_l3       <= l3_err_s;
      rd_l3        <= l3_rd_s;
      alu_q_l3     <= l3_alu_s;
      ram_rdata_l3 <= l3_rdata_s;
      if (capture_s) begin
        req_addr_r  <= {alu_q_l2[AW-1:2], 2'b00};
        req_we_r    <= store_l2;
        req_wdata_r <= store_l2 ? store_data(funct3_l2, wdata_l2) : 32'd0;
        req_wstrb_r <= store_l2 ? store_strb(funct3_l2, alu_q_l2[1:0]) : 4'b0000;
        req_f3_r    <= funct3_l2;
        req_off_r   <= alu_q_l2[1:0];
        req_rd_r    <= rd_l2;
        req_alu_r   <= alu_q_l2;
      end
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed, table-driven bench for lsu_stage. Inputs change 1 time unit after
// the rising edge; registered outputs are read there, stall_l2 one unit later.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_l2, load_l2, store_l2;
  logic [2:0]  funct3_l2;
  logic [4:0]  rd_l2;
  logic [31:0] alu_q_l2, wdata_l2;
  logic        stall_l2, valid_l3, load_l3, err_l3;
  logic [4:0]  rd_l3;
  logic [31:0] alu_q_l3, ram_rdata_l3;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_gnt, ram_rvalid;
  logic [31:0] ram_rdata;

  int n_vec = 0;
  int n_bad = 0;

  lsu_stage #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .valid_l2(valid_l2), .load_l2(load_l2), .store_l2(store_l2),
    .funct3_l2(funct3_l2), .rd_l2(rd_l2), .alu_q_l2(alu_q_l2), .wdata_l2(wdata_l2),
    .stall_l2(stall_l2), .valid_l3(valid_l3), .load_l3(load_l3), .err_l3(err_l3),
    .rd_l3(rd_l3), .alu_q_l3(alu_q_l3), .ram_rdata_l3(ram_rdata_l3),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_l2 = 1'b0; load_l2 = 1'b0; store_l2 = 1'b0;
    funct3_l2 = 3'b000; rd_l2 = 5'd0; alu_q_l2 = 32'd0; wdata_l2 = 32'd0;
  endtask

  // Full load: accept, gw grant waits, rw rvalid waits, then L3 check.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] word, input int gw, input int rw,
                         input logic [31:0] exp);
    valid_l2 = 1'b1; load_l2 = 1'b1; store_l2 = 1'b0;
    funct3_l2 = f3; rd_l2 = rd; alu_q_l2 = addr;
    #1 chk("ld_stall_accept", stall_l2, 1'b1);
    step();
    chk("ld_req", ram_req, 1'b1);
    chk("ld_we", ram_we, 1'b0);
    chk("ld_addr", ram_addr, {addr[31:2], 2'b00});
    chk("ld_bubble", {valid_l3, load_l3, err_l3, rd_l3}, 8'd0);
    for (int i = 0; i < gw; i++) begin
      ram_gnt = 1'b0;
      #1 chk("ld_stall_gntwait", stall_l2, 1'b1);
      step();
      chk("ld_req_hold", ram_req, 1'b1);
      chk("ld_addr_hold", ram_addr, {addr[31:2], 2'b00});
    end
    ram_gnt = 1'b1;
    #1 chk("ld_stall_gnt", stall_l2, 1'b1);
    step();
    ram_gnt = 1'b0;
    chk("ld_req_drop", ram_req, 1'b0);
    chk("ld_resp_bubble", {valid_l3, load_l3, rd_l3}, 7'd0);
    for (int i = 0; i < rw; i++) begin
      ram_rvalid = 1'b0; ram_rdata = 32'h0BAD_0BAD;
      #1 chk("ld_stall_rvwait", stall_l2, 1'b1);
      step();
    end
    ram_rvalid = 1'b1; ram_rdata = word;
    #1 chk("ld_stall_release", stall_l2, 1'b0);
    step();
    ram_rvalid = 1'b0; ram_rdata = 32'd0;
    idle_in();
    chk("ld_valid", valid_l3, 1'b1);
    chk("ld_load", load_l3, 1'b1);
    chk("ld_err", err_l3, 1'b0);
    chk("ld_rd", rd_l3, rd);
    chk("ld_data", ram_rdata_l3, exp);
  endtask

  // Full store: accept, gw grant waits with stable request, then L3 check.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input int gw, input logic [3:0] e_strb, input logic [31:0] e_wd);
    valid_l2 = 1'b1; load_l2 = 1'b0; store_l2 = 1'b1;
    funct3_l2 = f3; rd_l2 = 5'd9; alu_q_l2 = addr; wdata_l2 = wd;
    #1 chk("st_stall_accept", stall_l2, 1'b1);
    step();
    for (int i = 0; i <= gw; i++) begin
      chk("st_req", ram_req, 1'b1);
      chk("st_we", ram_we, 1'b1);
      chk("st_addr", ram_addr, {addr[31:2], 2'b00});
      chk("st_wstrb", ram_wstrb, e_strb);
      chk("st_wdata", ram_wdata, e_wd);
      chk("st_bubble", {valid_l3, rd_l3}, 6'd0);
      if (i < gw) begin
        ram_gnt = 1'b0;
        #1 chk("st_stall_gntwait", stall_l2, 1'b1);
        step();
      end
    end
    ram_gnt = 1'b1;
    #1 chk("st_stall_release", stall_l2, 1'b0);
    step();
    ram_gnt = 1'b0;
    idle_in();
    chk("st_valid", valid_l3, 1'b1);
    chk("st_rd", rd_l3, 5'd0);
    chk("st_load", load_l3, 1'b0);
    chk("st_err", err_l3, 1'b0);
    chk("st_req_drop", ram_req, 1'b0);
  endtask

  typedef struct {
    logic v, ld, st; logic [2:0] f3; logic [4:0] rd; logic [31:0] alu;
    logic e_v; logic [4:0] e_rd; logic e_err;
  } one_t;
  typedef struct {
    logic [2:0] f3; logic [31:0] addr; logic [4:0] rd; logic [31:0] word;
    int gw; int rw; logic [31:0] exp;
  } ld_t;
  typedef struct {
    logic [2:0] f3; logic [31:0] addr; logic [31:0] wd; int gw;
    logic [3:0] strb; logic [31:0] e_wd;
  } st_t;

  one_t ov[9];
  ld_t  lv[6];
  st_t  sv[5];

  initial begin
    ov[0] = '{1'b1, 1'b0, 1'b0, 3'b000,  5'd5, 32'h0000_1234, 1'b1,  5'd5, 1'b0};
    ov[1] = '{1'b0, 1'b0, 1'b0, 3'b000,  5'd7, 32'h0000_0055, 1'b0,  5'd0, 1'b0};
    ov[2] = '{1'b1, 1'b1, 1'b0, 3'b010,  5'd3, 32'h0000_0101, 1'b1,  5'd0, 1'b1};
    ov[3] = '{1'b1, 1'b1, 1'b0, 3'b001,  5'd4, 32'h0000_0103, 1'b1,  5'd0, 1'b1};
    ov[4] = '{1'b1, 1'b0, 1'b1, 3'b010,  5'd6, 32'h0000_0102, 1'b1,  5'd0, 1'b1};
    ov[5] = '{1'b1, 1'b1, 1'b0, 3'b011,  5'd8, 32'h0000_0100, 1'b1,  5'd0, 1'b1};
    ov[6] = '{1'b1, 1'b0, 1'b1, 3'b111,  5'd2, 32'h0000_0200, 1'b1,  5'd0, 1'b1};
    ov[7] = '{1'b0, 1'b1, 1'b0, 3'b010,  5'd3, 32'h0000_0101, 1'b0,  5'd0, 1'b0};
    ov[8] = '{1'b1, 1'b0, 1'b0, 3'b000, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 1'b0};

    lv[0] = '{3'b000, 32'h0000_0103, 5'd10, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80};
    lv[1] = '{3'b100, 32'h0000_0101, 5'd11, 32'h1234_8056, 0, 0, 32'h0000_0080};
    lv[2] = '{3'b000, 32'h0000_0102, 5'd12, 32'h127F_0000, 1, 0, 32'h0000_007F};
    lv[3] = '{3'b001, 32'h0000_0002, 5'd13, 32'h8001_0000, 0, 2, 32'hFFFF_8001};
    lv[4] = '{3'b001, 32'h0000_0000, 5'd14, 32'h1234_F00F, 0, 0, 32'hFFFF_F00F};
    lv[5] = '{3'b010, 32'h0000_0104, 5'd15, 32'hCAFE_BABE, 2, 1, 32'hCAFE_BABE};

    sv[0] = '{3'b001, 32'h0000_0202, 32'h0000_ABCD, 3, 4'b1100, 32'hABCD_ABCD};
    sv[1] = '{3'b000, 32'h0000_0201, 32'h1234_56A5, 0, 4'b0010, 32'hA5A5_A5A5};
    sv[2] = '{3'b000, 32'h0000_0203, 32'h0000_003C, 1, 4'b1000, 32'h3C3C_3C3C};
    sv[3] = '{3'b001, 32'h0000_0200, 32'h9999_5678, 0, 4'b0011, 32'h5678_5678};
    sv[4] = '{3'b010, 32'h0000_0300, 32'h1357_9BDF, 0, 4'b1111, 32'h1357_9BDF};

    rst = 1'b1; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = 32'd0;
    idle_in();
    step();
    step();
    chk("rst_l3", {valid_l3, load_l3, err_l3, rd_l3}, 8'd0);
    chk("rst_alu", alu_q_l3, 32'd0);
    chk("rst_rdata", ram_rdata_l3, 32'd0);
    chk("rst_ram", {ram_req, ram_we, ram_wstrb}, 6'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_stall", stall_l2, 1'b0);
    rst = 1'b0;

    // Single-cycle ops: pass-through, bubbles, misaligned and illegal.
    for (int i = 0; i < 9; i++) begin
      valid_l2 = ov[i].v; load_l2 = ov[i].ld; store_l2 = ov[i].st;
      funct3_l2 = ov[i].f3; rd_l2 = ov[i].rd; alu_q_l2 = ov[i].alu;
      #1 chk("one_stall", stall_l2, 1'b0);
      step();
      chk("one_valid", valid_l3, ov[i].e_v);
      chk("one_rd", rd_l3, ov[i].e_rd);
      chk("one_err", err_l3, ov[i].e_err);
      chk("one_load", load_l3, 1'b0);
      chk("one_noreq", ram_req, 1'b0);
      if (!ov[i].e_err) chk("one_alu", alu_q_l3, ov[i].alu);
      else chk("one_err_alive", valid_l3, 1'b1);
    end
    idle_in();
    step();

    for (int i = 0; i < 6; i++)
      do_load(lv[i].f3, lv[i].addr, lv[i].rd, lv[i].word, lv[i].gw, lv[i].rw, lv[i].exp);
    for (int i = 0; i < 5; i++)
      do_store(sv[i].f3, sv[i].addr, sv[i].wd, sv[i].gw, sv[i].strb, sv[i].e_wd);

    // Back-to-back: LHU immediately followed by SW, then an idle cycle.
    do_load(3'b101, 32'h0000_0002, 5'd20, 32'h8001_0000, 0, 0, 32'h0000_8001);
    do_store(3'b010, 32'h0000_0040, 32'h0F0F_1234, 0, 4'b1111, 32'h0F0F_1234);
    #1 chk("b2b_idle_stall", stall_l2, 1'b0);
    step();
    chk("b2b_no_dup", {valid_l3, ram_req}, 2'b00);

    // Reset while waiting in RESP, then a stray rvalid.
    valid_l2 = 1'b1; load_l2 = 1'b1; funct3_l2 = 3'b010; rd_l2 = 5'd17;
    alu_q_l2 = 32'h0000_0100;
    step();
    ram_gnt = 1'b1;
    step();
    ram_gnt = 1'b0;
    #1 chk("rstmid_resp_stall", stall_l2, 1'b1);
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
    chk("rstmid_req", ram_req, 1'b0);
    #1 chk("rstmid_stall", stall_l2, 1'b0);
    ram_rvalid = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    #1 chk("stray_stall", stall_l2, 1'b0);
    step();
    ram_rvalid = 1'b0;
    chk("stray_rdata", ram_rdata_l3, 32'd0);
    chk("stray_load", load_l3, 1'b0);
    chk("stray_valid", valid_l3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
